// File: rtl/spi_master_cfg.sv
// spi_master_cfg: parametrised full-duplex SPI master.
// A local controller hands over one word per ready/valid handshake; the block
// frames it with chip select, generates SCLK in the selected CPOL/CPHA mode,
// shifts the word out on mosi and assembles the reply from miso.
module spi_master_cfg #(
    parameter int DATA_W    = 8,
    parameter int CLK_DIV   = 4,
    parameter int CPOL      = 0,
    parameter int CPHA      = 0,
    parameter int MSB_FIRST = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_enable,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx_ready,
    input  logic              miso,
    output logic              mosi,
    output logic              cs,
    output logic              sclk,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy
);

    localparam int CNT_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int HALF_W = $clog2(2 * DATA_W);

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(2 * DATA_W - 1);
    localparam logic              SCLK_IDLE = (CPOL != 0);
    localparam logic              PHASE0    = (CPHA == 0);
    localparam logic              MSB_1ST   = (MSB_FIRST != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_GAP
    } state_t;

    // Bit that goes on the wire first for the configured bit order.
    function automatic logic f_first_bit(input logic [DATA_W-1:0] w);
        return MSB_1ST ? w[DATA_W-1] : w[0];
    endfunction

    // Discard the bit just transmitted, exposing the next one.
    function automatic logic [DATA_W-1:0] f_shift_out(input logic [DATA_W-1:0] w);
        return MSB_1ST ? {w[DATA_W-2:0], 1'b0} : {1'b0, w[DATA_W-1:1]};
    endfunction

    // Append a received bit at the end opposite to the transmit end.
    function automatic logic [DATA_W-1:0] f_shift_in(input logic [DATA_W-1:0] w,
                                                     input logic b);
        return MSB_1ST ? {w[DATA_W-2:0], b} : {b, w[DATA_W-1:1]};
    endfunction

    state_t              r_state;
    state_t              w_next_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [HALF_W-1:0]   r_half;
    logic [DATA_W-1:0]   r_tx;
    logic [DATA_W-1:0]   r_rx;
    logic                r_mosi;
    logic                r_sclk;
    logic                r_cs;
    logic [DATA_W-1:0]   r_rx_data;
    logic                r_rx_valid;

    logic                w_tx_ready;
    logic                w_busy;
    logic                w_cnt_last;
    logic                w_accept;
    logic                w_edge;
    logic                w_leading;
    logic                w_trailing;
    logic                w_last_half;
    logic                w_drive;
    logic                w_sample;
    logic                w_hold_done;
    logic [DATA_W-1:0]   w_tx_shift;

    assign w_cnt_last  = (r_cnt == CNT_LAST);
    assign w_accept    = tx_enable & w_tx_ready;
    // An SCLK edge happens at the end of every half-period while shifting;
    // even half-periods end in a leading edge, odd ones in a trailing edge.
    assign w_edge      = (r_state == S_SHIFT) & w_cnt_last;
    assign w_leading   = w_edge & ~r_half[0];
    assign w_trailing  = w_edge & r_half[0];
    assign w_last_half = (r_half == HALF_LAST);
    // Mode 0 presents bit 0 before the first edge, so the last trailing edge
    // has nothing left to present; mode 1 presents each bit on its leading edge.
    assign w_drive     = PHASE0 ? (w_trailing & ~w_last_half) : w_leading;
    assign w_sample    = PHASE0 ? w_leading : w_trailing;
    assign w_hold_done = (r_state == S_HOLD) & w_cnt_last;
    assign w_tx_shift  = f_shift_out(r_tx);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode and handshake/status outputs.
    always_comb begin
        w_next_state = r_state;
        w_tx_ready   = 1'b0;
        w_busy       = 1'b1;
        case (r_state)
            S_IDLE: begin
                w_tx_ready = 1'b1;
                w_busy     = 1'b0;
                if (tx_enable) begin
                    w_next_state = S_SETUP;
                end
            end
            S_SETUP: begin
                if (w_cnt_last) begin
                    w_next_state = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (w_cnt_last && w_last_half) begin
                    w_next_state = S_HOLD;
                end
            end
            S_HOLD: begin
                if (w_cnt_last) begin
                    w_next_state = S_GAP;
                end
            end
            S_GAP: begin
                if (w_cnt_last) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Divider: counts 0..CLK_DIV-1 in every non-idle state, parked at 0 in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_state == S_IDLE || w_cnt_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Half-period index within SHIFT, restarted outside it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_half <= '0;
        end else if (r_state != S_SHIFT) begin
            r_half <= '0;
        end else if (w_edge) begin
            r_half <= r_half + 1'b1;
        end
    end

    // SCLK: toggles on each half-period boundary, rests at CPOL otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sclk <= SCLK_IDLE;
        end else if (w_edge) begin
            r_sclk <= ~r_sclk;
        end else if (r_state != S_SHIFT) begin
            r_sclk <= SCLK_IDLE;
        end
    end

    // Chip select: drops on acceptance, rises as HOLD ends so GAP is deselected.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cs <= 1'b1;
        end else if (w_accept) begin
            r_cs <= 1'b0;
        end else if (w_hold_done) begin
            r_cs <= 1'b1;
        end
    end

    // Transmit shift register: loaded on acceptance, advanced on drive edges.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_tx <= tx_data;
        end else if (w_drive) begin
            r_tx <= w_tx_shift;
        end
    end

    // mosi only moves on drive edges (or SETUP entry in mode 0), never on sample edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mosi <= 1'b0;
        end else if (w_accept && PHASE0) begin
            r_mosi <= f_first_bit(tx_data);
        end else if (w_drive) begin
            r_mosi <= PHASE0 ? f_first_bit(w_tx_shift) : f_first_bit(r_tx);
        end
    end

    // Receive shift register: every bit is overwritten during a transfer.
    always_ff @(posedge clk) begin
        if (w_sample) begin
            r_rx <= f_shift_in(r_rx, miso);
        end
    end

    // Publish the assembled word with a single-cycle strobe as HOLD ends.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
        end else begin
            r_rx_valid <= w_hold_done;
            if (w_hold_done) begin
                r_rx_data <= r_rx;
            end
        end
    end

    assign tx_ready = w_tx_ready;
    assign busy     = w_busy;
    assign mosi     = r_mosi;
    assign cs       = r_cs;
    assign sclk     = r_sclk;
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;

endmodule

// File: tb/tb_spi_master_cfg.sv
// tb_spi_master_cfg: directed + randomized bench for spi_master_cfg in three
// configurations (mode 0 loopback, mode 3 with a slave model, 16-bit LSB-first
// with CLK_DIV=1).
`timescale 1ns/1ps
module tb_spi_master_cfg;

    localparam int A_LAT    = (2 * 8 + 2) * 2;
    localparam int A_PERIOD = (2 * 8 + 3) * 2 + 1;
    localparam int B_LAT    = (2 * 8 + 2) * 2;
    localparam int C_LAT    = (2 * 16 + 2) * 1;

    logic clk;
    logic rst;

    // Instance A: DATA_W=8, CLK_DIV=2, mode 0, MSB first, mosi looped to miso.
    logic        a_tx_enable, a_tx_ready, a_miso, a_mosi, a_cs, a_sclk, a_rx_valid, a_busy;
    logic [7:0]  a_tx_data, a_rx_data;
    // Instance B: DATA_W=8, CLK_DIV=2, mode 3, MSB first, slave model.
    logic        b_tx_enable, b_tx_ready, b_miso, b_mosi, b_cs, b_sclk, b_rx_valid, b_busy;
    logic [7:0]  b_tx_data, b_rx_data;
    // Instance C: DATA_W=16, CLK_DIV=1, mode 0, LSB first, loopback.
    logic        c_tx_enable, c_tx_ready, c_miso, c_mosi, c_cs, c_sclk, c_rx_valid, c_busy;
    logic [15:0] c_tx_data, c_rx_data;

    assign a_miso = a_mosi;
    assign c_miso = c_mosi;

    spi_master_cfg #(.DATA_W(8), .CLK_DIV(2), .CPOL(0), .CPHA(0), .MSB_FIRST(1)) u_a (
        .clk(clk), .rst(rst), .tx_enable(a_tx_enable), .tx_data(a_tx_data),
        .tx_ready(a_tx_ready), .miso(a_miso), .mosi(a_mosi), .cs(a_cs), .sclk(a_sclk),
        .rx_data(a_rx_data), .rx_valid(a_rx_valid), .busy(a_busy));

    spi_master_cfg #(.DATA_W(8), .CLK_DIV(2), .CPOL(1), .CPHA(1), .MSB_FIRST(1)) u_b (
        .clk(clk), .rst(rst), .tx_enable(b_tx_enable), .tx_data(b_tx_data),
        .tx_ready(b_tx_ready), .miso(b_miso), .mosi(b_mosi), .cs(b_cs), .sclk(b_sclk),
        .rx_data(b_rx_data), .rx_valid(b_rx_valid), .busy(b_busy));

    spi_master_cfg #(.DATA_W(16), .CLK_DIV(1), .CPOL(0), .CPHA(0), .MSB_FIRST(0)) u_c (
        .clk(clk), .rst(rst), .tx_enable(c_tx_enable), .tx_data(c_tx_data),
        .tx_ready(c_tx_ready), .miso(c_miso), .mosi(c_mosi), .cs(c_cs), .sclk(c_sclk),
        .rx_data(c_rx_data), .rx_valid(c_rx_valid), .busy(c_busy));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int ncmp  = 0;
    int nfail = 0;

    // Monitor for instance A, sampled on the falling clock edge.
    // Negedge k follows posedge k, so an acceptance seen here lands on posedge k+1.
    int         ncyc = 0;
    int         a_acc_q[$];
    int         a_val_q[$];
    logic [7:0] a_rxd_q[$];
    int         a_cs_runs[$];
    int         a_cs_run = 0;
    int         a_rise   = 0;

    always @(negedge clk) begin
        ncyc = ncyc + 1;
        if (a_tx_enable === 1'b1 && a_tx_ready === 1'b1) a_acc_q.push_back(ncyc + 1);
        if (a_rx_valid === 1'b1) begin
            a_val_q.push_back(ncyc);
            a_rxd_q.push_back(a_rx_data);
        end
        if (a_cs === 1'b1) begin
            a_cs_run = a_cs_run + 1;
        end else begin
            if (a_cs_run > 0) a_cs_runs.push_back(a_cs_run);
            a_cs_run = 0;
        end
    end

    always @(posedge a_sclk) if (a_cs === 1'b0) a_rise = a_rise + 1;

    // Mode-3 slave: presents its reply MSB first on falling SCLK, captures mosi on rising SCLK.
    logic [7:0] b_reply;
    logic [7:0] b_sl_tx;
    logic [7:0] b_sl_rx;
    initial b_miso = 1'b0;
    always @(negedge b_cs) begin
        b_sl_tx = b_reply;
        b_sl_rx = 8'h00;
    end
    always @(negedge b_sclk) if (b_cs === 1'b0) begin
        b_miso  = b_sl_tx[7];
        b_sl_tx = {b_sl_tx[6:0], 1'b0};
    end
    always @(posedge b_sclk) if (b_cs === 1'b0) b_sl_rx = {b_sl_rx[6:0], b_mosi};

    // Mode-0 slave for C: records every bit it samples on rising SCLK, in wire order.
    logic c_bits[$];
    always @(posedge c_sclk) if (c_cs === 1'b0) c_bits.push_back(c_mosi);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic a_clear();
        a_acc_q.delete();
        a_val_q.delete();
        a_rxd_q.delete();
        a_cs_runs.delete();
        a_cs_run = 0;
        a_rise   = 0;
    endtask

    task automatic a_send(input logic [7:0] w);
        a_tx_data   = w;
        a_tx_enable = 1'b1;
        tick();
        a_tx_enable = 1'b0;
    endtask

    task automatic a_wait(input int n_exp);
        int t = 0;
        while (a_val_q.size() < n_exp && t < 300) begin
            tick();
            t++;
        end
        chk("a_wait_valid", 32'(a_val_q.size() >= n_exp), 32'd1);
    endtask

    // Cycles from the acceptance edge to the first rx_valid seen on B.
    task automatic b_wait(output int n);
        n = 0;
        while (b_rx_valid !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
    endtask

    task automatic c_wait(output int n);
        n = 0;
        while (c_rx_valid !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
    endtask

    logic [7:0]  w8;
    logic [15:0] w16;
    logic [15:0] seen16;
    int          n;

    initial begin
        rst = 1'b1;
        a_tx_enable = 1'b0; a_tx_data = 8'h00;
        b_tx_enable = 1'b0; b_tx_data = 8'h00; b_reply = 8'h00;
        c_tx_enable = 1'b0; c_tx_data = 16'h0000;
        ticks(3);

        // Reset state.
        chk("rst_cs", a_cs, 1);
        chk("rst_sclk_cpol0", a_sclk, 0);
        chk("rst_sclk_cpol1", b_sclk, 1);
        chk("rst_mosi", a_mosi, 0);
        chk("rst_rx_data", a_rx_data, 0);
        chk("rst_rx_valid", a_rx_valid, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_tx_ready", a_tx_ready, 1);
        rst = 1'b0;
        ticks(2);

        // Mode 0 loopback of 8'hA5.
        a_clear();
        a_send(8'hA5);
        chk("a5_busy", a_busy, 1);
        chk("a5_tx_ready", a_tx_ready, 0);
        chk("a5_cs_low", a_cs, 0);
        a_wait(1);
        ticks(5);
        chk("a5_rx_data", a_rxd_q.size() > 0 ? a_rxd_q[0] : 8'hxx, 8'hA5);
        chk("a5_latency", a_val_q.size() > 0 ? a_val_q[0] - a_acc_q[0] : -1, A_LAT);
        chk("a5_one_pulse", a_val_q.size(), 1);
        chk("a5_sclk_rises", a_rise, 8);
        chk("a5_sclk_idle", a_sclk, 0);
        chk("a5_cs_idle", a_cs, 1);

        // Random loopback words.
        for (int k = 0; k < 4; k++) begin
            a_clear();
            w8 = 8'($urandom_range(0, 255));
            a_send(w8);
            a_wait(1);
            ticks(5);
            chk("a_rand_rx", a_rxd_q.size() > 0 ? a_rxd_q[0] : 8'hxx, w8);
            chk("a_rand_latency", a_val_q.size() > 0 ? a_val_q[0] - a_acc_q[0] : -1, A_LAT);
        end

        // Request and data change while busy are ignored.
        a_clear();
        w8 = 8'($urandom_range(0, 255));
        a_send(w8);
        ticks(10);
        a_tx_data   = ~w8;
        a_tx_enable = 1'b1;
        tick();
        a_tx_enable = 1'b0;
        a_wait(1);
        ticks(60);
        chk("busy_accepts", a_acc_q.size(), 1);
        chk("busy_valids", a_val_q.size(), 1);
        chk("busy_rx", a_rxd_q.size() > 0 ? a_rxd_q[0] : 8'hxx, w8);

        // Streaming with tx_enable held high.
        a_clear();
        a_tx_data   = 8'h01;
        a_tx_enable = 1'b1;
        tick();
        a_tx_data = 8'h02;
        n = 0;
        while (a_acc_q.size() < 2 && n < 200) begin
            tick();
            n++;
        end
        a_tx_enable = 1'b0;
        a_wait(2);
        ticks(5);
        chk("stream_rx0", a_rxd_q.size() > 1 ? a_rxd_q[0] : 8'hxx, 8'h01);
        chk("stream_rx1", a_rxd_q.size() > 1 ? a_rxd_q[1] : 8'hxx, 8'h02);
        chk("stream_accept_period", a_acc_q.size() > 1 ? a_acc_q[1] - a_acc_q[0] : -1, A_PERIOD);
        chk("stream_valid_period", a_val_q.size() > 1 ? a_val_q[1] - a_val_q[0] : -1, A_PERIOD);
        chk("stream_cs_gap", a_cs_runs.size() == 2 ? a_cs_runs[1] : -1, 2 + 1);

        // Reset ten cycles into a transfer.
        a_clear();
        a_send(8'($urandom_range(0, 255)));
        ticks(9);
        rst = 1'b1;
        #1;
        chk("midrst_cs", a_cs, 1);
        chk("midrst_sclk", a_sclk, 0);
        chk("midrst_rx_data", a_rx_data, 0);
        chk("midrst_busy", a_busy, 0);
        tick();
        rst = 1'b0;
        tick();
        chk("midrst_tx_ready", a_tx_ready, 1);
        ticks(60);
        chk("midrst_no_valid", a_val_q.size(), 0);

        // Mode 3 against the slave model.
        chk("m3_sclk_idle", b_sclk, 1);
        for (int k = 0; k < 4; k++) begin
            if (k == 0) begin
                b_reply = 8'h3C;
                w8      = 8'hC3;
            end else begin
                b_reply = 8'($urandom_range(0, 255));
                w8      = 8'($urandom_range(0, 255));
            end
            b_tx_data   = w8;
            b_tx_enable = 1'b1;
            tick();
            b_tx_enable = 1'b0;
            b_wait(n);
            chk("m3_latency", n, B_LAT);
            chk("m3_rx_data", b_rx_data, {24'h0, b_reply});
            chk("m3_slave_rx", b_sl_rx, {24'h0, w8});
            chk("m3_sclk_after", b_sclk, 1);
            ticks(5);
        end

        // 16-bit LSB-first, CLK_DIV=1.
        for (int k = 0; k < 3; k++) begin
            w16 = (k == 0) ? 16'h8001 : 16'($urandom_range(0, 65535));
            c_bits.delete();
            c_tx_data   = w16;
            c_tx_enable = 1'b1;
            tick();
            c_tx_enable = 1'b0;
            c_wait(n);
            chk("c16_latency", n, C_LAT);
            chk("c16_bit_count", c_bits.size(), 16);
            seen16 = 16'h0000;
            for (int i = 0; i < c_bits.size() && i < 16; i++) seen16[i] = c_bits[i];
            chk("c16_slave_word", seen16, w16);
            chk("c16_rx_data", c_rx_data, w16);
            if (k == 0) begin
                chk("c16_first_bit", c_bits.size() > 15 ? c_bits[0] : 1'bx, 1);
                chk("c16_second_bit", c_bits.size() > 15 ? c_bits[1] : 1'bx, 0);
                chk("c16_last_bit", c_bits.size() > 15 ? c_bits[15] : 1'bx, 1);
            end
            ticks(4);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
